// File: rtl/alu_seq.sv
// Sequenced ALU with a valid/ready front end and a registered, held result.
// Most opcodes finish in one cycle. Divide uses a WIDTH-cycle restoring divider.
//
// state | meaning
// IDLE  | ready for a request; the last result is still held on the outputs
// DIV   | restoring divider running, one quotient bit per cycle
// DONE  | result valid, waiting for out_ready
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             arith_flag,
  output logic             logic_flag,
  output logic             cmp_flag,
  output logic             shift_flag,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ABS  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_XNOR = 4'b1001;
  localparam logic [3:0] OP_EQ   = 4'b1010;
  localparam logic [3:0] OP_GT   = 4'b1011;
  localparam logic [3:0] OP_LT   = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;
  localparam logic [3:0] OP_SHL  = 4'b1110;

  // Class encoding: {arith, logic, cmp, shift}
  localparam logic [3:0] CLS_ARITH = 4'b1000;
  localparam logic [3:0] CLS_LOGIC = 4'b0100;
  localparam logic [3:0] CLS_CMP   = 4'b0010;
  localparam logic [3:0] CLS_SHIFT = 4'b0001;
  localparam logic [3:0] CLS_NONE  = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             load_single;
  logic             load_div;
  logic             div_start;

  logic [WIDTH-1:0] op_max;
  logic [WIDTH-1:0] op_min;
  logic [WIDTH-1:0] op_res;
  logic [3:0]       op_cls;
  logic             op_dz;

  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH:0]   rem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] quo_nxt;

  logic [3:0]       cls;

  // Single-cycle result, class and divide classification from the live inputs
  always_comb begin
    op_max    = (a >= b) ? a : b;
    op_min    = (a >= b) ? b : a;
    op_res    = '0;
    op_cls    = CLS_NONE;
    op_dz     = 1'b0;
    div_start = 1'b0;
    unique case (alu_func)
      OP_ADD:  begin op_res = a + b;                    op_cls = CLS_ARITH; end
      OP_ABS:  begin op_res = (a >= b) ? a - b : b - a; op_cls = CLS_ARITH; end
      OP_MUL:  begin op_res = a * b;                    op_cls = CLS_ARITH; end
      OP_DIV: begin
        op_cls = CLS_ARITH;
        if (op_min == '0) begin
          op_res = '1;
          op_dz  = 1'b1;
        end else begin
          div_start = 1'b1;
        end
      end
      OP_AND:  begin op_res = a & b;    op_cls = CLS_LOGIC; end
      OP_OR:   begin op_res = a | b;    op_cls = CLS_LOGIC; end
      OP_NAND: begin op_res = ~(a & b); op_cls = CLS_LOGIC; end
      OP_NOR:  begin op_res = ~(a | b); op_cls = CLS_LOGIC; end
      OP_XOR:  begin op_res = a ^ b;    op_cls = CLS_LOGIC; end
      OP_XNOR: begin op_res = ~(a ^ b); op_cls = CLS_LOGIC; end
      OP_EQ:   begin op_res = (a == b) ? WIDTH'(1) : '0; op_cls = CLS_CMP; end
      OP_GT:   begin op_res = (a > b)  ? WIDTH'(2) : '0; op_cls = CLS_CMP; end
      OP_LT:   begin op_res = (a < b)  ? WIDTH'(3) : '0; op_cls = CLS_CMP; end
      OP_SHR:  begin op_res = a >> 1;   op_cls = CLS_SHIFT; end
      OP_SHL:  begin op_res = a << 1;   op_cls = CLS_SHIFT; end
      default: begin op_res = '0;       op_cls = CLS_NONE;  end
    endcase
  end

  // One restoring step. The compare is done at full width, so the subtract only
  // needs WIDTH+1 bits: a kept difference is always below the divisor.
  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    q_bit    = (rem_sh >= {2'b00, dvsr});
    rem_diff = rem_sh[WIDTH:0] - {1'b0, dvsr};
    rem_nxt  = q_bit ? rem_diff : rem_sh[WIDTH:0];
    quo_nxt  = {quo[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    load_single = 1'b0;
    load_div    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (div_start) begin
            state_nxt = DIV;
          end else begin
            state_nxt   = DONE;
            load_single = 1'b1;
          end
        end
      end
      DIV: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          load_div  = 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_out  <= '0;
      cls      <= CLS_NONE;
      div_zero <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      dvsr     <= '0;
      cnt      <= '0;
    end else begin
      if (load_single) begin
        alu_out  <= op_res;
        cls      <= op_cls;
        div_zero <= op_dz;
      end else if (load_div) begin
        // last quotient bit is folded in on the same edge that enters DONE
        alu_out  <= quo_nxt;
        cls      <= CLS_ARITH;
        div_zero <= 1'b0;
      end

      if (state == IDLE && in_valid && div_start) begin
        quo  <= op_max;
        rem  <= '0;
        dvsr <= op_min;
        cnt  <= CW'(WIDTH - 1);
      end else if (state == DIV) begin
        quo <= quo_nxt;
        rem <= rem_nxt;
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign arith_flag = cls[3];
  assign logic_flag = cls[2];
  assign cmp_flag   = cls[1];
  assign shift_flag = cls[0];

endmodule
